// File: rtl/stack_data_mem.sv
// Data memory with an empty-descending hardware stack: direct LOAD/STORE,
// PUSH/POP through a stack pointer, registered read port and sticky error flags.
module stack_data_mem #(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 8,
    parameter int unsigned SP_INIT  = 2**ADDR_W - 1,
    parameter int unsigned SP_LIMIT = 2**ADDR_W - 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] rn_in,
    input  logic [DATA_W-1:0] npc_in,
    input  logic              wsel,
    input  logic              sp_load,
    input  logic [ADDR_W-1:0] sp_load_val,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] sp_out,
    output logic              ovf,
    output logic              unf,
    output logic              ill
);

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_PUSH  = 3'b011,
        OP_POP   = 3'b100
    } op_e;

    localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(SP_INIT);
    localparam logic [ADDR_W-1:0] SP_FULL  = ADDR_W'(SP_LIMIT);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] sp;
    logic              accept_p0;
    logic              is_load_p0, is_store_p0, is_push_p0, is_pop_p0, is_ill_p0;
    logic              full_p0, empty_p0;
    logic              wr_en_p0, rd_en_p0;
    logic [ADDR_W-1:0] wr_addr_p0, rd_addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              ovf_set_p0, unf_set_p0, ill_set_p0;
    logic [DATA_W-1:0] rdata_p1;
    logic              rvalid_p1;

    // Stage p0: decode; sp_load and reset both swallow the same-cycle op
    assign accept_p0   = op_valid && !sp_load && !rst;
    assign is_load_p0  = accept_p0 && (op == OP_LOAD);
    assign is_store_p0 = accept_p0 && (op == OP_STORE);
    assign is_push_p0  = accept_p0 && (op == OP_PUSH);
    assign is_pop_p0   = accept_p0 && (op == OP_POP);
    assign is_ill_p0   = accept_p0 && (op > OP_POP);

    assign full_p0  = (sp == SP_FULL);
    assign empty_p0 = (sp == SP_EMPTY);

    assign wdata_p0   = wsel ? rn_in : npc_in;
    assign wr_en_p0   = is_store_p0 || (is_push_p0 && !full_p0);
    assign wr_addr_p0 = is_store_p0 ? addr_in : sp;
    assign rd_en_p0   = is_load_p0 || (is_pop_p0 && !empty_p0);
    assign rd_addr_p0 = is_load_p0 ? addr_in : sp + ADDR_W'(1);

    assign ovf_set_p0 = is_push_p0 && full_p0;
    assign unf_set_p0 = is_pop_p0 && empty_p0;
    assign ill_set_p0 = is_ill_p0;

    always_ff @(posedge clk) begin
        if (wr_en_p0)
            mem[wr_addr_p0] <= wdata_p0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sp <= SP_EMPTY;
        else if (sp_load)
            sp <= sp_load_val;
        else if (is_push_p0 && !full_p0)
            sp <= sp - ADDR_W'(1);
        else if (is_pop_p0 && !empty_p0)
            sp <= sp + ADDR_W'(1);
    end

    // A newly raised error outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            ill <= 1'b0;
        end else begin
            ovf <= ovf_set_p0 || (ovf && !clr_flags);
            unf <= unf_set_p0 || (unf && !clr_flags);
            ill <= ill_set_p0 || (ill && !clr_flags);
        end
    end

    // Stage p1: registered read, sampled before this edge's write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1  <= '0;
            rvalid_p1 <= 1'b0;
        end else begin
            rvalid_p1 <= rd_en_p0;
            if (rd_en_p0)
                rdata_p1 <= mem[rd_addr_p0];
        end
    end

    // Reset arriving while a read is in flight cancels its pulse immediately
    assign rvalid = rvalid_p1 && !rst;
    assign rdata  = rdata_p1;
    assign sp_out = sp;

endmodule

// File: tb/tb_stack_data_mem.sv
// Directed bench for stack_data_mem: expected read data is queued at issue
// time and matched by an independent monitor whenever rvalid is seen.
module tb_stack_data_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [2:0] op;
    logic [7:0] addr_in, rn_in, npc_in, sp_load_val;
    logic       wsel, sp_load, clr_flags;
    logic [7:0] rdata, sp_out;
    logic       rvalid, ovf, unf, ill;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    stack_data_mem dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .addr_in(addr_in),
        .rn_in(rn_in), .npc_in(npc_in), .wsel(wsel), .sp_load(sp_load),
        .sp_load_val(sp_load_val), .clr_flags(clr_flags), .rdata(rdata),
        .rvalid(rvalid), .sp_out(sp_out), .ovf(ovf), .unf(unf), .ill(ill)
    );

    always #5 clk = ~clk;

    // Monitor: every rvalid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: got rdata=%h, required no rvalid", rdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL rdata: got %h, required %h", rdata, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // rn_in and npc_in always differ so a wrong wsel shows up as wrong data
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] d,
                         input logic ws);
        op_valid = 1'b1;
        op       = o;
        addr_in  = a;
        wsel     = ws;
        rn_in    = ws ? d : ~d;
        npc_in   = ws ? ~d : d;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        op        = 3'b000;
        sp_load   = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic flags(input string name, input logic [2:0] req);
        chk(name, {29'd0, ovf, unf, ill}, {29'd0, req});
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = 3'b000; addr_in = '0; rn_in = '0;
        npc_in = '0; wsel = 1'b0; sp_load = 1'b0; sp_load_val = '0; clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sp", sp_out, 8'hFF);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_rvalid", rvalid, 1'b0);
        flags("reset_flags", 3'b000);
        rst = 1'b0;

        // STORE then LOAD, then an idle cycle: rdata must hold
        issue(3'b010, 8'h10, 8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        issue(3'b001, 8'h10, 8'h00, 1'b1);
        issue(3'b000, 8'h00, 8'h00, 1'b1);
        chk("rdata_hold", rdata, 8'hA5);
        chk("rvalid_low_idle", rvalid, 1'b0);

        // Stack push/pop with both write-data sources
        issue(3'b011, 8'h00, 8'h3C, 1'b0);
        chk("sp_push1", sp_out, 8'hFE);
        issue(3'b011, 8'h00, 8'h7E, 1'b1);
        chk("sp_push2", sp_out, 8'hFD);
        exp_q.push_back(8'h7E);
        issue(3'b100, 8'h00, 8'h00, 1'b1);
        chk("sp_pop1", sp_out, 8'hFE);
        exp_q.push_back(8'h3C);
        issue(3'b100, 8'h00, 8'h00, 1'b1);
        chk("sp_pop2", sp_out, 8'hFF);
        flags("flags_after_pops", 3'b000);

        // Underflow, then clear
        issue(3'b100, 8'h00, 8'h00, 1'b1);
        flags("underflow", 3'b010);
        chk("sp_after_unf", sp_out, 8'hFF);
        clr_flags = 1'b1;
        issue(3'b000, 8'h00, 8'h00, 1'b1);
        flags("unf_cleared", 3'b000);

        // Read-old-data: LOAD then STORE same address next cycle
        issue(3'b010, 8'h20, 8'h11, 1'b1);
        exp_q.push_back(8'h11);
        issue(3'b001, 8'h20, 8'h00, 1'b1);
        issue(3'b010, 8'h20, 8'h22, 1'b0);
        exp_q.push_back(8'h22);
        issue(3'b001, 8'h20, 8'h00, 1'b1);

        // PUSH then POP back to back
        issue(3'b011, 8'h00, 8'h5A, 1'b1);
        exp_q.push_back(8'h5A);
        issue(3'b100, 8'h00, 8'h00, 1'b1);
        chk("sp_push_pop", sp_out, 8'hFF);

        // Fill to the limit; the 16th push overflows and must not write 0xF0
        issue(3'b010, 8'hF0, 8'hC3, 1'b1);
        for (int i = 0; i < 15; i++)
            issue(3'b011, 8'h00, 8'h30 + 8'(i), 1'b1);
        chk("sp_at_limit", sp_out, 8'hF0);
        flags("no_ovf_at_15", 3'b000);
        issue(3'b011, 8'h00, 8'hEE, 1'b1);
        flags("overflow", 3'b100);
        chk("sp_after_ovf", sp_out, 8'hF0);
        exp_q.push_back(8'hC3);
        issue(3'b001, 8'hF0, 8'h00, 1'b1);
        exp_q.push_back(8'h30);
        issue(3'b001, 8'hFF, 8'h00, 1'b1);
        clr_flags = 1'b1;
        issue(3'b011, 8'h00, 8'hEE, 1'b1);
        flags("error_beats_clear", 3'b100);
        clr_flags = 1'b1;
        issue(3'b000, 8'h00, 8'h00, 1'b1);
        flags("ovf_cleared", 3'b000);

        // sp_load wins over a same-cycle PUSH
        issue(3'b010, 8'hFF, 8'h99, 1'b1);
        sp_load = 1'b1; sp_load_val = 8'hF8;
        issue(3'b011, 8'h00, 8'h44, 1'b1);
        chk("sp_loaded", sp_out, 8'hF8);
        flags("sp_load_no_flags", 3'b000);
        exp_q.push_back(8'h99);
        issue(3'b001, 8'hFF, 8'h00, 1'b1);

        // Illegal op
        issue(3'b110, 8'h00, 8'h00, 1'b1);
        flags("illegal", 3'b001);
        chk("sp_after_ill", sp_out, 8'hF8);

        // Modulo wrap of SP
        sp_load = 1'b1; sp_load_val = 8'h00;
        issue(3'b000, 8'h00, 8'h00, 1'b1);
        issue(3'b011, 8'h00, 8'h66, 1'b1);
        chk("sp_wrap", sp_out, 8'hFF);
        exp_q.push_back(8'h66);
        issue(3'b001, 8'h00, 8'h00, 1'b1);

        // Reset right after LOAD acceptance kills the pending pulse
        issue(3'b001, 8'h10, 8'h00, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_sp", sp_out, 8'hFF);
        flags("rst_flags", 3'b000);
        exp_q.push_back(8'hA5);
        issue(3'b001, 8'h10, 8'h00, 1'b1);
        issue(3'b000, 8'h00, 8'h00, 1'b1);
        issue(3'b000, 8'h00, 8'h00, 1'b1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
